muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit owning the HI/LO register pair. It sits in the EXE stage beside the ALU. It replaces single-cycle 64-bit ALU multiply/divide with a WIDTH-cycle shift-add / restoring-divide engine that supports signed and unsigned operation. While an operation is in flight, it requests a pipeline stall for any HI/LO read or new issue, so the pipeline stays coherent.

---
 rtl/muldiv_unit.sv | 134 +++++++++++++
 tb/tb_muldiv_unit.sv | 133 +++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply/divide engine owning the HI/LO pair
// Ports: clk/rst_n clock and async active-low reset; start/op/src_a/src_b issue an
// operation; flush aborts it; hilo_read flags an mfhi/mflo in ID; busy/done/div_by_zero
// report engine status; stall_req holds the pipeline; hi/lo are the result registers.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             hilo_read,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, prod;
  logic [WIDTH-1:0] b_q, b_d, a_q, a_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] mag_a, mag_b, addend, div_rem;
  logic [WIDTH:0] mul_sum, div_sh;
  logic is_div_q, is_div_d, neg_q, neg_d, rem_neg_q, rem_neg_d, dz_q, dz_d;
  logic done_q, done_d, dbz_q, dbz_d, signed_op, div_ge;
  // acc holds {product high, multiplier} for multiply and {remainder, dividend/quotient} for divide
  always_comb begin
    signed_op = ~op[0];
    mag_a = (signed_op & src_a[WIDTH-1]) ? -src_a : src_a;
    mag_b = (signed_op & src_b[WIDTH-1]) ? -src_b : src_b;
    addend = acc_q[0] ? b_q : {WIDTH{1'b0}};
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    div_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge = div_sh >= {1'b0, b_q};
    div_rem = div_sh[WIDTH-1:0] - b_q;
    prod = neg_q ? -acc_q : acc_q;
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    b_d = b_q;
    a_d = a_q;
    hi_d = hi_q;
    lo_d = lo_q;
    is_div_d = is_div_q;
    neg_d = neg_q;
    rem_neg_d = rem_neg_q;
    dz_d = dz_q;
    done_d = 1'b0;
    dbz_d = 1'b0;
    if (flush) begin
      state_d = IDLE;
      cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: if (start && !op[2]) begin
          state_d = CALC;
          cnt_d = CW'(WIDTH);
          acc_d = {{WIDTH{1'b0}}, mag_a};
          b_d = mag_b;
          a_d = src_a;
          is_div_d = op[1];
          neg_d = signed_op & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
          rem_neg_d = signed_op & src_a[WIDTH-1];
          dz_d = src_b == '0;
        end else if (start && !op[1]) begin
          hi_d = op[0] ? hi_q : src_a;
          lo_d = op[0] ? src_a : lo_q;
          done_d = 1'b1;
        end
        CALC: begin
          cnt_d = cnt_q - 1'b1;
          acc_d = is_div_q ? {div_ge ? div_rem : div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge}
                           : {mul_sum, acc_q[WIDTH-1:1]};
          state_d = (cnt_q == CW'(1)) ? FIX : CALC;
        end
        FIX: begin
          state_d = IDLE;
          done_d = 1'b1;
          dbz_d = is_div_q & dz_q;
          // divide-by-zero returns the raw dividend in HI and all ones in LO
          hi_d = !is_div_q ? prod[2*WIDTH-1:WIDTH] : dz_q ? a_q :
                 rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
          lo_d = !is_div_q ? prod[WIDTH-1:0] : dz_q ? {WIDTH{1'b1}} :
                 neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      b_q <= '0;
      a_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      is_div_q <= 1'b0;
      neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      b_q <= b_d;
      a_q <= a_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      is_div_q <= is_div_d;
      neg_q <= neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q <= dz_d;
      done_q <= done_d;
      dbz_q <= dbz_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign div_by_zero = dbz_q;
  assign stall_req = busy & (hilo_read | start);
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit at WIDTH=32 and WIDTH=8
module tb_muldiv_unit;
  localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3, MTHI = 3'd4, MTLO = 3'd5;
  logic clk = 1'b0;
  logic rst_n;
  logic start, flush, hilo_read, busy, done, dbz, stall;
  logic [2:0] op;
  logic [31:0] a, b, hi, lo;
  logic start8, flush8, hilo8, busy8, done8, dbz8, stall8;
  logic [2:0] op8;
  logic [7:0] a8, b8, hi8, lo8;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(a), .src_b(b),
    .flush(flush), .hilo_read(hilo_read), .busy(busy), .done(done),
    .div_by_zero(dbz), .stall_req(stall), .hi(hi), .lo(lo)
  );
  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .src_a(a8), .src_b(b8),
    .flush(flush8), .hilo_read(hilo8), .busy(busy8), .done(done8),
    .div_by_zero(dbz8), .stall_req(stall8), .hi(hi8), .lo(lo8)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Issues at the current negedge, waits out busy, then checks latency and results
  task automatic run(input bit w8, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] ehi, input logic [31:0] elo, input logic edz, input string tag);
    int n = 0;
    int dn = 0;
    if (w8) begin
      start8 = 1'b1; op8 = o; a8 = x[7:0]; b8 = y[7:0];
    end else begin
      start = 1'b1; op = o; a = x; b = y;
    end
    @(negedge clk);
    start = 1'b0;
    start8 = 1'b0;
    while ((w8 ? busy8 : busy) && n < 200) begin
      n++;
      if (w8 ? done8 : done) dn++;
      @(negedge clk);
    end
    chk({tag, " latency"}, 64'(n), w8 ? 64'd9 : 64'd33);
    chk({tag, " early done"}, 64'(dn), 64'd0);
    chk({tag, " done"}, 64'(w8 ? done8 : done), 64'd1);
    chk({tag, " hi"}, w8 ? 64'(hi8) : 64'(hi), 64'(ehi));
    chk({tag, " lo"}, w8 ? 64'(lo8) : 64'(lo), 64'(elo));
    chk({tag, " dbz"}, 64'(w8 ? dbz8 : dbz), 64'(edz));
  endtask
  initial begin
    rst_n = 1'b0;
    start = 1'b0; flush = 1'b0; hilo_read = 1'b0; op = 3'd0; a = '0; b = '0;
    start8 = 1'b0; flush8 = 1'b0; hilo8 = 1'b0; op8 = 3'd0; a8 = '0; b8 = '0;
    #1;
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset dbz", 64'(dbz), 64'd0);
    chk("reset hi8", 64'(hi8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "mult -3*7");
    run(0, DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div -7/2");
    run(0, DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, "divu 7/2");
    run(0, DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, "div overflow");
    run(0, DIVU, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, 1'b1, "divu by zero");
    run(0, MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, "multu 3*5");
    @(negedge clk);
    chk("done single pulse", 64'(done), 64'd0);
    hilo_read = 1'b1;
    #1 chk("stall idle read", 64'(stall), 64'd0);
    hilo_read = 1'b0;
    op = MTHI; a = 32'hA5A5A5A5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mthi hi", 64'(hi), 64'hA5A5A5A5);
    chk("mthi lo kept", 64'(lo), 64'd15);
    chk("mthi done", 64'(done), 64'd1);
    chk("mthi busy", 64'(busy), 64'd0);
    op = MULT; a = 32'd5; b = 32'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    hilo_read = 1'b1;
    #1 chk("stall on read", 64'(stall), 64'd1);
    hilo_read = 1'b0;
    #1 chk("stall quiet", 64'(stall), 64'd0);
    op = DIVU; start = 1'b1;
    #1 chk("stall on issue", 64'(stall), 64'd1);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy", 64'(busy), 64'd0);
    chk("flush done", 64'(done), 64'd0);
    chk("flush hi", 64'(hi), 64'hA5A5A5A5);
    chk("flush lo", 64'(lo), 64'd15);
    @(negedge clk);
    chk("flush no late done", 64'(done), 64'd0);
    op = MTLO; a = 32'h1111; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush beats mtlo lo", 64'(lo), 64'd15);
    chk("flush beats mtlo done", 64'(done), 64'd0);
    op = MULTU; a = 32'd9; b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst hi", 64'(hi), 64'd0);
    chk("async rst lo", 64'(lo), 64'd0);
    chk("async rst busy", 64'(busy), 64'd0);
    chk("async rst done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "post-reset divu");
    run(1, MULTU, 32'hFF, 32'hFF, 32'hFE, 32'h01, 1'b0, "w8 multu");
    run(1, MULT, 32'h80, 32'h80, 32'h40, 32'h00, 1'b0, "w8 mult");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
